nsnr_flag_bank: RTL and testbench
=================================

NSNR_FLAG_BANK -- requirements
Module: nsnr_flag_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of independent set/reset channels (legal 1..32).
REQ-002 SHALL have parameter SYNC, default 2, input synchroniser stages per nset/nrst bit (legal 0..3; 0 = inputs used directly).
REQ-003 SHALL have parameter MODE, default 0, conflict resolution: 0 reset-dominant, 1 set-dominant, 2 hold-on-conflict.
REQ-004 SHALL have parameter EDGE, default 0, trigger mode: 0 level (active-low), 1 falling-edge of synchronised input.
REQ-005 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-006 ck  input  1  clock, all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 nset  input  WIDTH  per-channel active-low set request.
REQ-009 nrst  input  WIDTH  per-channel active-low reset request.
REQ-010 clr  input  WIDTH  per-channel active-high clear, already synchronous to ck.
REQ-011 ack  input  1  active-high interrupt acknowledge.
REQ-012 q  output  WIDTH  registered flag state.
REQ-013 nq  output  WIDTH  bitwise complement of q, always.
REQ-014 chg  output  WIDTH  one-cycle pulse per channel whose q changed.
REQ-015 irq  output  1  sticky "some flag changed" indication.

Function
REQ-016 Each nset/nrst bit SHALL pass through SYNC flops; synchroniser flops reset to 1 (inactive).
REQ-017 EDGE=0: effective set s = ~nset_sync, effective reset r = ~nrst_sync.
REQ-018 EDGE=1: s = prev_nset & ~nset_sync (1->0 transition), same for r; prev registers reset to 1; a held-low input produces exactly one event.
REQ-019 Per channel next q: clr=1 -> 0 (highest priority); else s&r -> per MODE (0: 0, 1: 1, 2: hold); else s -> 1; else r -> 0; else hold.
REQ-020 Latency: input change stable before edge n SHALL be reflected in q after edge n+SYNC (SYNC=0: edge n); clr reflected after edge n.
REQ-021 chg[i] SHALL be registered, asserted for exactly the cycle in which q[i] shows its new value, and 0 when q[i] holds or is re-set to the same value.
REQ-022 irq SHALL set on the edge where any chg bit would assert; ack=1 clears irq on the next edge.
REQ-023 Simultaneous ack and new change in same cycle: irq SHALL remain 1 (set wins).
REQ-024 ack while irq=0 SHALL have no effect.
REQ-025 Channels SHALL be fully independent; no cross-channel interaction except OR into irq.
REQ-026 nq SHALL equal ~q in every cycle including during and after reset; no combinational path from inputs to q/nq/chg/irq.

Reset
REQ-027 rst=1 at an edge SHALL force q=0, nq=all 1, chg=0, irq=0, synchroniser and prev registers to all 1.
REQ-028 rst SHALL dominate clr, ack, nset and nrst; inputs asserted during reset SHALL not generate chg or irq on release unless still active (level mode) after synchronisation.
REQ-029 Reset mid-operation SHALL discard in-flight synchroniser contents; first post-reset q update no earlier than SYNC edges after rst deasserts.

Verification (WIDTH=4, SYNC=2 unless stated)
REQ-030 Reset then idle (nset=nrst=4'hF, clr=0): q=4'h0, nq=4'hF, chg=0, irq=0 for 10 cycles.
REQ-031 MODE=0, EDGE=0: nset=4'hE at edge 0 -> q=4'h1, chg=4'h1 one cycle, irq=1 after edge 2; ack one cycle -> irq=0 next edge, q stays 4'h1.
REQ-032 Conflict nset=nrst=4'h0 with q=4'h5: MODE=0 -> q=4'h0, chg=4'h5; MODE=1 -> q=4'hF, chg=4'hA; MODE=2 -> q=4'h5, chg=0, irq unchanged.
REQ-033 EDGE=1: hold nset[2]=0 for 8 cycles -> q[2]=1 once, single chg pulse; nrst[2] pulse low 1 cycle (with SYNC=0) -> q[2]=0, one chg pulse.
REQ-034 clr=4'h8 same cycle as nset[3]=0 (SYNC=0, MODE=1) -> q[3]=0; simultaneous ack and new change -> irq stays 1.
REQ-035 rst asserted while nset=4'h0 propagating in synchroniser -> q=0 after reset; on release with nset=4'hF, q, chg, irq remain 0.

Source files
------------

// File: rtl/nsnr_flag_bank.sv
// Bank of independent active-low set/reset flags with optional input synchronisers,
// edge or level triggering, per-channel change pulses and a sticky interrupt.
module nsnr_flag_bank #(
    parameter int WIDTH = 8,
    parameter int SYNC  = 2,
    parameter int MODE  = 0,
    parameter int EDGE  = 0
) (
    input  logic             ck,
    input  logic             rst,
    input  logic [WIDTH-1:0] nset,
    input  logic [WIDTH-1:0] nrst,
    input  logic [WIDTH-1:0] clr,
    input  logic             ack,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic [WIDTH-1:0] chg,
    output logic             irq
);

    logic [WIDTH-1:0] nset_sync;
    logic [WIDTH-1:0] nrst_sync;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q_next;

    // Synchroniser stages idle high so a reset looks like "no request" to the flags.
    if (SYNC == 0) begin : g_nosync
        assign nset_sync = nset;
        assign nrst_sync = nrst;
    end else begin : g_sync
        logic [WIDTH-1:0] set_pipe [SYNC];
        logic [WIDTH-1:0] rst_pipe [SYNC];

        always_ff @(posedge ck) begin
            if (rst) begin
                for (int i = 0; i < SYNC; i++) begin
                    set_pipe[i] <= '1;
                    rst_pipe[i] <= '1;
                end
            end else begin
                set_pipe[0] <= nset;
                rst_pipe[0] <= nrst;
                for (int i = 1; i < SYNC; i++) begin
                    set_pipe[i] <= set_pipe[i-1];
                    rst_pipe[i] <= rst_pipe[i-1];
                end
            end
        end

        assign nset_sync = set_pipe[SYNC-1];
        assign nrst_sync = rst_pipe[SYNC-1];
    end

    if (EDGE == 1) begin : g_edge
        logic [WIDTH-1:0] prev_nset;
        logic [WIDTH-1:0] prev_nrst;

        always_ff @(posedge ck) begin
            if (rst) begin
                prev_nset <= '1;
                prev_nrst <= '1;
            end else begin
                prev_nset <= nset_sync;
                prev_nrst <= nrst_sync;
            end
        end

        assign s = prev_nset & ~nset_sync;
        assign r = prev_nrst & ~nrst_sync;
    end else begin : g_level
        assign s = ~nset_sync;
        assign r = ~nrst_sync;
    end

    // Clear beats everything; a simultaneous set and reset is resolved by MODE.
    always_comb begin
        q_next = q;
        for (int i = 0; i < WIDTH; i++) begin
            if (clr[i]) begin
                q_next[i] = 1'b0;
            end else if (s[i] && r[i]) begin
                if (MODE == 0) begin
                    q_next[i] = 1'b0;
                end else if (MODE == 1) begin
                    q_next[i] = 1'b1;
                end
            end else if (s[i]) begin
                q_next[i] = 1'b1;
            end else if (r[i]) begin
                q_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            q   <= '0;
            chg <= '0;
            irq <= 1'b0;
        end else begin
            q   <= q_next;
            chg <= q_next ^ q;
            if (|(q_next ^ q)) begin
                irq <= 1'b1;
            end else if (ack) begin
                irq <= 1'b0;
            end
        end
    end

    assign nq = ~q;

endmodule

// File: tb/tb_nsnr_flag_bank.sv
// Directed testbench for nsnr_flag_bank: several parameterisations share one stimulus
// bus and each scenario task checks the instances it targets against hand-worked values.
module tb_nsnr_flag_bank;

    localparam int M0 = 0;  // MODE0 EDGE0 SYNC2
    localparam int M1 = 1;  // MODE1 EDGE0 SYNC2
    localparam int M2 = 2;  // MODE2 EDGE0 SYNC2
    localparam int E  = 3;  // MODE0 EDGE1 SYNC2
    localparam int C  = 4;  // MODE1 EDGE0 SYNC0
    localparam int ES = 5;  // MODE0 EDGE1 SYNC0

    logic       ck = 1'b0;
    logic       rst;
    logic       ack;
    logic [3:0] nset;
    logic [3:0] nrst;
    logic [3:0] clr;

    logic [3:0] q   [6];
    logic [3:0] nq  [6];
    logic [3:0] chg [6];
    logic       irq [6];

    int checks = 0;
    int failures = 0;

    always #5 ck = ~ck;

    nsnr_flag_bank #(.WIDTH(4), .SYNC(2), .MODE(0), .EDGE(0)) dut_m0 (
        .ck(ck), .rst(rst), .nset(nset), .nrst(nrst), .clr(clr), .ack(ack),
        .q(q[M0]), .nq(nq[M0]), .chg(chg[M0]), .irq(irq[M0]));
    nsnr_flag_bank #(.WIDTH(4), .SYNC(2), .MODE(1), .EDGE(0)) dut_m1 (
        .ck(ck), .rst(rst), .nset(nset), .nrst(nrst), .clr(clr), .ack(ack),
        .q(q[M1]), .nq(nq[M1]), .chg(chg[M1]), .irq(irq[M1]));
    nsnr_flag_bank #(.WIDTH(4), .SYNC(2), .MODE(2), .EDGE(0)) dut_m2 (
        .ck(ck), .rst(rst), .nset(nset), .nrst(nrst), .clr(clr), .ack(ack),
        .q(q[M2]), .nq(nq[M2]), .chg(chg[M2]), .irq(irq[M2]));
    nsnr_flag_bank #(.WIDTH(4), .SYNC(2), .MODE(0), .EDGE(1)) dut_e (
        .ck(ck), .rst(rst), .nset(nset), .nrst(nrst), .clr(clr), .ack(ack),
        .q(q[E]), .nq(nq[E]), .chg(chg[E]), .irq(irq[E]));
    nsnr_flag_bank #(.WIDTH(4), .SYNC(0), .MODE(1), .EDGE(0)) dut_c (
        .ck(ck), .rst(rst), .nset(nset), .nrst(nrst), .clr(clr), .ack(ack),
        .q(q[C]), .nq(nq[C]), .chg(chg[C]), .irq(irq[C]));
    nsnr_flag_bank #(.WIDTH(4), .SYNC(0), .MODE(0), .EDGE(1)) dut_es (
        .ck(ck), .rst(rst), .nset(nset), .nrst(nrst), .clr(clr), .ack(ack),
        .q(q[ES]), .nq(nq[ES]), .chg(chg[ES]), .irq(irq[ES]));

    // Inputs change and outputs are sampled just after each falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic do_reset();
        rst = 1'b1; nset = 4'hF; nrst = 4'hF; clr = 4'h0; ack = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; nset = 4'h0; nrst = 4'hF; clr = 4'hF; ack = 1'b1;
        step(3);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (q[k] !== 4'h0 || nq[k] !== 4'hF || chg[k] !== 4'h0 || irq[k] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_hold dut%0d: q=%h nq=%h chg=%h irq=%b required q=0 nq=f chg=0 irq=0",
                         k, q[k], nq[k], chg[k], irq[k]);
            end
        end
        nset = 4'hF; clr = 4'h0; ack = 1'b0;
        step(1);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            checks++;
            if (q[M0] !== 4'h0 || nq[M0] !== 4'hF || chg[M0] !== 4'h0 || irq[M0] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_idle cycle%0d: q=%h nq=%h chg=%h irq=%b required q=0 nq=f chg=0 irq=0",
                         c, q[M0], nq[M0], chg[M0], irq[M0]);
            end
            checks++;
            if (q[C] !== 4'h0 || irq[C] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_idle_sync0 cycle%0d: q=%h irq=%b required q=0 irq=0", c, q[C], irq[C]);
            end
        end
    endtask

    task automatic test_level_set();
        do_reset();
        nset = 4'hE;
        step(1);
        checks++;
        if (q[M0] !== 4'h0) begin
            failures++; $display("[TB] FAIL level_lat1: q=%h required 0", q[M0]);
        end
        step(1);
        checks++;
        if (q[M0] !== 4'h0) begin
            failures++; $display("[TB] FAIL level_lat2: q=%h required 0", q[M0]);
        end
        step(1);
        checks++;
        if (q[M0] !== 4'h1 || nq[M0] !== 4'hE || chg[M0] !== 4'h1 || irq[M0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL level_set: q=%h nq=%h chg=%h irq=%b required q=1 nq=e chg=1 irq=1",
                     q[M0], nq[M0], chg[M0], irq[M0]);
        end
        step(1);
        checks++;
        if (q[M0] !== 4'h1 || chg[M0] !== 4'h0 || irq[M0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL level_hold: q=%h chg=%h irq=%b required q=1 chg=0 irq=1", q[M0], chg[M0], irq[M0]);
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++;
        if (irq[M0] !== 1'b0 || q[M0] !== 4'h1) begin
            failures++; $display("[TB] FAIL level_ack: irq=%b q=%h required irq=0 q=1", irq[M0], q[M0]);
        end
        nset = 4'hF;
        step(3);
        checks++;
        if (q[M0] !== 4'h1 || chg[M0] !== 4'h0 || irq[M0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL level_release: q=%h chg=%h irq=%b required q=1 chg=0 irq=0", q[M0], chg[M0], irq[M0]);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        nset = 4'hA;
        step(3);
        checks++;
        if (q[M0] !== 4'h5 || q[M1] !== 4'h5 || q[M2] !== 4'h5) begin
            failures++;
            $display("[TB] FAIL conflict_setup: q0=%h q1=%h q2=%h required 5 5 5", q[M0], q[M1], q[M2]);
        end
        nset = 4'hF;
        step(1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++;
        if (irq[M0] !== 1'b0 || irq[M2] !== 1'b0) begin
            failures++; $display("[TB] FAIL conflict_ack: irq0=%b irq2=%b required 0 0", irq[M0], irq[M2]);
        end
        nset = 4'h0; nrst = 4'h0;
        step(3);
        checks++;
        if (q[M0] !== 4'h0 || chg[M0] !== 4'h5 || irq[M0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL conflict_mode0: q=%h chg=%h irq=%b required q=0 chg=5 irq=1", q[M0], chg[M0], irq[M0]);
        end
        checks++;
        if (q[M1] !== 4'hF || nq[M1] !== 4'h0 || chg[M1] !== 4'hA) begin
            failures++;
            $display("[TB] FAIL conflict_mode1: q=%h nq=%h chg=%h required q=f nq=0 chg=a", q[M1], nq[M1], chg[M1]);
        end
        checks++;
        if (q[M2] !== 4'h5 || chg[M2] !== 4'h0 || irq[M2] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL conflict_mode2: q=%h chg=%h irq=%b required q=5 chg=0 irq=0", q[M2], chg[M2], irq[M2]);
        end
        nset = 4'hF; nrst = 4'hF;
        step(3);
    endtask

    task automatic test_edge();
        int cnt_e;
        int cnt_es;
        do_reset();
        cnt_e = 0; cnt_es = 0;
        nset = 4'hB;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (chg[E][2]) cnt_e++;
            if (chg[ES][2]) cnt_es++;
            if (i == 7) nset = 4'hF;
        end
        checks++;
        if (cnt_e !== 1 || cnt_es !== 1) begin
            failures++; $display("[TB] FAIL edge_set_pulses: sync2=%0d sync0=%0d required 1 1", cnt_e, cnt_es);
        end
        checks++;
        if (q[E] !== 4'h4 || q[ES] !== 4'h4) begin
            failures++; $display("[TB] FAIL edge_set_q: sync2=%h sync0=%h required 4 4", q[E], q[ES]);
        end
        cnt_e = 0; cnt_es = 0;
        nrst = 4'hB;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (i == 0) begin
                nrst = 4'hF;
                checks++;
                if (q[ES] !== 4'h0 || chg[ES] !== 4'h4) begin
                    failures++;
                    $display("[TB] FAIL edge_rst_sync0: q=%h chg=%h required q=0 chg=4", q[ES], chg[ES]);
                end
            end
            if (chg[E][2]) cnt_e++;
            if (chg[ES][2]) cnt_es++;
        end
        checks++;
        if (cnt_e !== 1 || cnt_es !== 1 || q[E] !== 4'h0 || q[ES] !== 4'h0) begin
            failures++;
            $display("[TB] FAIL edge_rst_pulses: cnt2=%0d cnt0=%0d q2=%h q0=%h required 1 1 0 0",
                     cnt_e, cnt_es, q[E], q[ES]);
        end
    endtask

    task automatic test_clr_ack();
        do_reset();
        clr = 4'h8; nset = 4'h7;
        step(1);
        checks++;
        if (q[C] !== 4'h0 || chg[C] !== 4'h0 || irq[C] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clr_wins: q=%h chg=%h irq=%b required q=0 chg=0 irq=0", q[C], chg[C], irq[C]);
        end
        clr = 4'h0;
        step(1);
        checks++;
        if (q[C] !== 4'h8 || chg[C] !== 4'h8 || irq[C] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clr_release: q=%h chg=%h irq=%b required q=8 chg=8 irq=1", q[C], chg[C], irq[C]);
        end
        nset = 4'h6; ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++;
        if (q[C] !== 4'h9 || chg[C] !== 4'h1 || irq[C] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ack_vs_change: q=%h chg=%h irq=%b required q=9 chg=1 irq=1", q[C], chg[C], irq[C]);
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++;
        if (irq[C] !== 1'b0 || chg[C] !== 4'h0) begin
            failures++; $display("[TB] FAIL ack_clear: irq=%b chg=%h required irq=0 chg=0", irq[C], chg[C]);
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++;
        if (irq[C] !== 1'b0 || q[C] !== 4'h9) begin
            failures++; $display("[TB] FAIL ack_idle: irq=%b q=%h required irq=0 q=9", irq[C], q[C]);
        end
        nset = 4'hF; clr = 4'h1;
        step(1);
        clr = 4'h0;
        checks++;
        if (q[C] !== 4'h8 || chg[C] !== 4'h1 || irq[C] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clr_bit0: q=%h chg=%h irq=%b required q=8 chg=1 irq=1", q[C], chg[C], irq[C]);
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        nset = 4'h0;
        step(1);
        rst = 1'b1; nset = 4'hF;
        step(1);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(1);
            checks++;
            if (q[M0] !== 4'h0 || chg[M0] !== 4'h0 || irq[M0] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_inflight cycle%0d: q=%h chg=%h irq=%b required q=0 chg=0 irq=0",
                         c, q[M0], chg[M0], irq[M0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; nset = 4'hF; nrst = 4'hF; clr = 4'h0; ack = 1'b0;
        $display("[TB] starting nsnr_flag_bank tests");
        test_reset();
        test_level_set();
        test_conflict();
        test_edge();
        test_clr_ack();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
